// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
//   Registered stage behind the 16-bit ALU. Each accepted ALU result is
//   captured with its derived {C,V,N,Z} flags and destination address into a
//   2-entry FIFO skid buffer and offered to register-file writeback over a
//   valid/ready handshake. The architectural flag register is updated only
//   when an entry with set_flags=1 is dequeued (committed).
//
//   Optional feature macro: ALU_WB_DIV0_TRAP_EN
//     defined   : a div (op 5) with operand_b==0 is handshaken, dropped, and
//                 raises sticky div0_err (cleared by div0_clr, set wins).
//     undefined : divides are enqueued normally, div0_err is tied 0.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake; in_ready depends on state only
//   alu_*             ALU result and adder flags
//   op_select         opcode of the result (0 add .. 5 div, 6/7 illegal)
//   operand_b         ALU b operand (divide-by-zero detection only)
//   dest_addr         destination register of the result
//   set_flags         committing this entry updates the flag register
//   wb_valid/wb_ready downstream writeback handshake
//   wb_data/wb_addr   head entry; held while stalled or empty
//   flags             architectural {C,V,N,Z}
//   occupancy         entries held, 0..2
//   illegal_op        sticky: an op 6/7 was accepted
//   div0_err/div0_clr sticky divide-by-zero and its clear
module alu_writeback_stage #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       alu_result,
  input  logic              alu_cout,
  input  logic              alu_overflow,
  input  logic              alu_no,
  input  logic              alu_zo,
  input  logic [2:0]        op_select,
  input  logic [15:0]       operand_b,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              set_flags,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [15:0]       wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [3:0]        flags,
  output logic [1:0]        occupancy,
  output logic              illegal_op,
  output logic              div0_err,
  input  logic              div0_clr
);

  if (DEPTH != 2) begin : g_depth_check
    $error("alu_writeback_stage: DEPTH must be 2");
  end

  typedef struct packed {
    logic [15:0]       data;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        flg;   // {C,V,N,Z}
    logic              set_flags;
  } entry_t;

  entry_t            mem [2];
  entry_t            new_entry;
  logic [1:0]        count, count_nxt, remain;
  logic              rd_ptr, wr_ptr;
  logic              push, pop, enq, illegal_in, trap;
  logic [15:0]       wb_data_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [3:0]        flags_q;
  logic              illegal_q;

  // in_ready comes straight off the count register, so a pop in the same
  // cycle never frees space for a push until the following cycle.
  assign in_ready   = (count != 2'd2);
  assign wb_valid   = (count != 2'd0);
  assign occupancy  = count;
  assign push       = in_valid & in_ready;
  assign pop        = wb_valid & wb_ready;
  assign illegal_in = op_select[2] & op_select[1];
  assign enq        = push & ~illegal_in & ~trap;

  // Adder ops carry the ALU's own flags; logic/mul/div derive N,Z from the
  // result and report no carry/overflow.
  always_comb begin
    new_entry.data      = alu_result;
    new_entry.addr      = dest_addr;
    new_entry.set_flags = set_flags;
    if (op_select == 3'd0 || op_select == 3'd1)
      new_entry.flg = {alu_cout, alu_overflow, alu_no, alu_zo};
    else
      new_entry.flg = {1'b0, 1'b0, alu_result[15], (alu_result == 16'h0000)};
  end

  assign count_nxt = count + {1'b0, enq} - {1'b0, pop};
  // Entries still held after this cycle's pop, before the push lands.
  assign remain    = count - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      count <= count_nxt;
      if (pop) rd_ptr <= ~rd_ptr;
      if (enq) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
    end
  end

  // Output registers track the head entry so the presented data never moves
  // while stalled, and simply hold when the buffer drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_q <= 16'h0000;
      wb_addr_q <= '0;
    end else if (count_nxt != 2'd0) begin
      if (remain == 2'd0) begin
        wb_data_q <= new_entry.data;
        wb_addr_q <= new_entry.addr;
      end else begin
        wb_data_q <= mem[rd_ptr ^ pop].data;
        wb_addr_q <= mem[rd_ptr ^ pop].addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q   <= 4'h0;
      illegal_q <= 1'b0;
    end else begin
      if (pop && mem[rd_ptr].set_flags) flags_q <= mem[rd_ptr].flg;
      if (push && illegal_in) illegal_q <= 1'b1;
    end
  end

  assign wb_data    = wb_data_q;
  assign wb_addr    = wb_addr_q;
  assign flags      = flags_q;
  assign illegal_op = illegal_q;

`ifdef ALU_WB_DIV0_TRAP_EN
  logic div0_q;
  assign trap = push & (op_select == 3'd5) & (operand_b == 16'h0000);
  always_ff @(posedge clk) begin
    if (rst)           div0_q <= 1'b0;
    else if (trap)     div0_q <= 1'b1;
    else if (div0_clr) div0_q <= 1'b0;
  end
  assign div0_err = div0_q;
`else
  logic unused_div0;
  assign unused_div0 = ^{operand_b, div0_clr};
  assign trap        = 1'b0;
  assign div0_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
module tb_alu_writeback_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, alu_cout, alu_overflow, alu_no, alu_zo;
  logic        set_flags, wb_ready, div0_clr;
  logic [15:0] alu_result, operand_b;
  logic [2:0]  op_select, dest_addr;
  logic        in_ready, wb_valid, illegal_op, div0_err;
  logic [15:0] wb_data;
  logic [2:0]  wb_addr;
  logic [3:0]  flags;
  logic [1:0]  occupancy;

  int checks = 0;
  int failures = 0;

  alu_writeback_stage #(.ADDR_W(3), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .alu_no(alu_no), .alu_zo(alu_zo), .op_select(op_select),
    .operand_b(operand_b), .dest_addr(dest_addr), .set_flags(set_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_addr(wb_addr), .flags(flags), .occupancy(occupancy),
    .illegal_op(illegal_op), .div0_err(div0_err), .div0_clr(div0_clr)
  );

  always #5 clk = ~clk;

`ifdef ALU_WB_DIV0_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Reference model: a queue of pending writebacks plus architectural state.
  typedef struct {
    logic [15:0] d;
    logic [2:0]  a;
    logic [3:0]  f;
    bit          sf;
  } ment_t;

  ment_t       q[$];
  logic [3:0]  m_flags;
  bit          m_ill, m_d0;
  logic [15:0] m_last_d;
  logic [2:0]  m_last_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    ment_t e;
    bit push, pop, trap;
    if (rst) begin
      q.delete();
      m_flags = 4'h0; m_ill = 0; m_d0 = 0; m_last_d = 16'h0; m_last_a = 3'h0;
      return;
    end
    push = in_valid && (q.size() < 2);
    pop  = (q.size() > 0) && wb_ready;
    trap = TRAP_EN && push && op_select == 3'd5 && operand_b == 16'h0;
    if (pop) begin
      e = q.pop_front();
      if (e.sf) m_flags = e.f;
    end
    if (push) begin
      if (op_select >= 3'd6) m_ill = 1;
      else if (!trap) begin
        e.d = alu_result; e.a = dest_addr; e.sf = set_flags;
        if (op_select <= 3'd1) e.f = {alu_cout, alu_overflow, alu_no, alu_zo};
        else e.f = {2'b00, alu_result[15], alu_result == 16'h0};
        q.push_back(e);
      end
    end
    if (trap) m_d0 = 1;
    else if (TRAP_EN && div0_clr) m_d0 = 0;
    if (q.size() > 0) begin m_last_d = q[0].d; m_last_a = q[0].a; end
  endtask

  task automatic compare_all();
    chk("wb_valid",   {31'b0, wb_valid},    {31'b0, q.size() > 0});
    chk("occupancy",  {30'b0, occupancy},   q.size());
    chk("in_ready",   {31'b0, in_ready},    {31'b0, q.size() < 2});
    chk("wb_data",    {16'b0, wb_data},     {16'b0, m_last_d});
    chk("wb_addr",    {29'b0, wb_addr},     {29'b0, m_last_a});
    chk("flags",      {28'b0, flags},       {28'b0, m_flags});
    chk("illegal_op", {31'b0, illegal_op},  {31'b0, m_ill});
    chk("div0_err",   {31'b0, div0_err},    {31'b0, m_d0});
  endtask

  // Inputs were set just after a negedge; the model predicts the state after
  // the next posedge, which is compared at the following negedge.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    rst = 0; in_valid = 0; wb_ready = 0; div0_clr = 0; set_flags = 0;
    alu_result = 16'h0; alu_cout = 0; alu_overflow = 0; alu_no = 0; alu_zo = 0;
    op_select = 3'd0; operand_b = 16'h1; dest_addr = 3'd0;
  endtask

  task automatic drive_push(input logic [2:0] op, input logic [15:0] res,
                            input logic [2:0] d, input bit sf);
    in_valid = 1; op_select = op; alu_result = res; dest_addr = d; set_flags = sf;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    chk("reset wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset wb_data",  {16'b0, wb_data},  32'd0);

    // add result 0, cout=1, zo=1 -> flags 1001 after commit
    idle(); drive_push(3'd0, 16'h0000, 3'd3, 1); alu_cout = 1; alu_zo = 1; wb_ready = 1;
    tick();
    chk("t1 wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("t1 wb_addr",  {29'b0, wb_addr},  32'd3);
    idle(); wb_ready = 1;
    tick();
    chk("t1 flags", {28'b0, flags}, 32'h9);

    // stall with two entries
    idle(); drive_push(3'd2, 16'h1111, 3'd1, 0); tick();
    idle(); drive_push(3'd2, 16'h2222, 3'd2, 0); tick();
    chk("t2 occupancy", {30'b0, occupancy}, 32'd2);
    chk("t2 in_ready",  {31'b0, in_ready},  32'd0);
    idle(); drive_push(3'd3, 16'h3333, 3'd2, 0); tick();   // refused while full
    chk("t2 wb_data", {16'b0, wb_data}, 32'h1111);
    idle(); wb_ready = 1; drive_push(3'd3, 16'h3333, 3'd2, 0); tick(); // pop, push refused
    chk("t2 second", {16'b0, wb_data}, 32'h2222);
    chk("t2 ready back", {31'b0, in_ready}, 32'd1);

    // occupancy 1 with simultaneous push/pop
    idle(); wb_ready = 1; drive_push(3'd4, 16'hBEEF, 3'd5, 0); tick();
    chk("t3 occupancy", {30'b0, occupancy}, 32'd1);
    chk("t3 wb_data", {16'b0, wb_data}, 32'hBEEF);
    idle(); wb_ready = 1; tick();

    // AND 8000 sets flags, OR 0001 does not
    idle(); wb_ready = 1; drive_push(3'd2, 16'h8000, 3'd1, 1); tick();
    idle(); wb_ready = 1; drive_push(3'd3, 16'h0001, 3'd2, 0); tick();
    idle(); wb_ready = 1; tick();
    chk("t4 flags", {28'b0, flags}, 32'h2);

    // illegal op then div by zero
    idle(); drive_push(3'd6, 16'h5555, 3'd4, 1); tick();
    chk("t5 illegal", {31'b0, illegal_op}, 32'd1);
    chk("t5 occupancy", {30'b0, occupancy}, 32'd0);
    idle(); drive_push(3'd5, 16'h1234, 3'd6, 1); operand_b = 16'h0; wb_ready = 0; tick();
`ifdef ALU_WB_DIV0_TRAP_EN
    chk("t5 div0_err", {31'b0, div0_err}, 32'd1);
    chk("t5 div0 drop", {31'b0, wb_valid}, 32'd0);
    idle(); div0_clr = 1; tick();
    chk("t5 div0 clr", {31'b0, div0_err}, 32'd0);
`else
    chk("t5 div0_err", {31'b0, div0_err}, 32'd0);
    chk("t5 div data", {16'b0, wb_data}, 32'h1234);
    idle(); wb_ready = 1; tick();
`endif

    // reset with two entries held
    idle(); drive_push(3'd0, 16'hAAAA, 3'd1, 1); alu_cout = 1; tick();
    idle(); drive_push(3'd0, 16'hBBBB, 3'd2, 1); tick();
    idle(); rst = 1; wb_ready = 1; tick();
    chk("t6 wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("t6 occupancy", {30'b0, occupancy}, 32'd0);
    chk("t6 flags", {28'b0, flags}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst          = ($urandom_range(0, 99) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      wb_ready     = ($urandom_range(0, 2) != 0);
      div0_clr     = ($urandom_range(0, 7) == 0);
      op_select    = ($urandom_range(0, 19) == 0) ? 3'(6 + $urandom_range(0, 1))
                                                  : 3'($urandom_range(0, 5));
      alu_result   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      operand_b    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      {alu_cout, alu_overflow, alu_no, alu_zo} = 4'($urandom);
      dest_addr    = 3'($urandom);
      set_flags    = 1'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
